// File: rtl/vga_timing_pkg.sv
// Shared video-mode constants and timing helpers for vga_timing_gen.
// Mode tables cover 640x480@60 and 800x600@60.
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic int h_total(
    input int act, input int fp,
    input int sw, input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(
    input int act, input int fp,
    input int sw, input int bp
  );
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Pixel-enable qualified shift register, W bits wide and D stages deep.
// Every stage resets to RST_VAL; D=0 is a plain wire.
module vga_sig_delay #(
  parameter int           W       = 1,
  parameter int           D       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (D == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_sr
      logic [W-1:0] sr_q [D];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++)
            sr_q[i] <= RST_VAL;
        end else if (ce_i) begin
          sr_q[0] <= d_i;
          for (int i = 1; i < D; i++)
            sr_q[i] <= sr_q[i-1];
        end
      end

      assign q_o = sr_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator driven by a pixel enable.
// Define VGA_TIMING_SYNC_DLY_EN to delay hsync/vsync/de by SYNC_DLY pixels.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int SYNC_DLY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             sof,
  output logic             eol
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] EOL_X =
    CNT_W'(H_ACTIVE - 1);

  // One extra bit so a window ending at TOTAL cannot wrap.
  localparam logic [CNT_W:0] H_ACT =
    (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG =
    (CNT_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W:0] HS_END =
    (CNT_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_ACT =
    (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEG =
    (CNT_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W:0] VS_END =
    (CNT_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam sync_t SYNC_RST = '{
    hs: ~HS_POL,
    vs: ~VS_POL,
    de: 1'b0
  };

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] x_q, y_q;
  logic [CNT_W:0]   h_ext, v_ext;
  logic             h_last, v_last;
  logic             h_act, v_act;
  sync_t            sync_d, sync_q, sync_o;
  logic             sof_d, sof_q;
  logic             eol_d, eol_q;

  always_comb begin
    h_ext   = {1'b0, h_cnt_q};
    v_ext   = {1'b0, v_cnt_q};
    h_last  = h_cnt_q == H_LAST;
    v_last  = v_cnt_q == V_LAST;
    h_cnt_d = h_last ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last)
      v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
    h_act     = h_ext < H_ACT;
    v_act     = v_ext < V_ACT;
    sync_d.de = h_act && v_act;
    sync_d.hs = (h_ext >= HS_BEG && h_ext < HS_END)
              ? HS_POL : ~HS_POL;
    sync_d.vs = (v_ext >= VS_BEG && v_ext < VS_END)
              ? VS_POL : ~VS_POL;
    sof_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    eol_d = (h_cnt_q == EOL_X) && v_act;
  end

  // Outputs decode the pre-increment count, so they trail it by one pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sync_q  <= SYNC_RST;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else if (pix_ce) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= h_cnt_q;
      y_q     <= v_cnt_q;
      sync_q  <= sync_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

`ifdef VGA_TIMING_SYNC_DLY_EN
  vga_sig_delay #(
    .W       ($bits(sync_t)),
    .D       (SYNC_DLY),
    .RST_VAL (SYNC_RST)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .ce_i  (pix_ce),
    .d_i   (sync_q),
    .q_o   (sync_o)
  );
`else
  assign sync_o = sync_q;
`endif

  assign x     = x_q;
  assign y     = y_q;
  assign hsync = sync_o.hs;
  assign vsync = sync_o.vs;
  assign de    = sync_o.de;
  assign sof   = sof_q;
  assign eol   = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 15x8 raster.
// Stimulus pushes per-clock expectations; a negedge monitor pops them.
module tb_vga_timing_gen;

  localparam int CW  = 4;
  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam bit HP  = 1'b0;
  localparam bit VP  = 1'b1;
  localparam int DLY = 2;
  localparam int HT  = 15;
  localparam int VT  = 8;
  localparam int FT  = HT * VT;

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit sof;
    bit eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_ce = 1'b0;
  logic [CW-1:0] x, y;
  logic          hsync, vsync, de, sof, eol;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  bit rst_cur = 1'b1;
  bit ce_cur = 1'b0;
  bit started = 1'b0;
  bit done = 1'b0;
  int n = 0;
  bit hh[DLY];
  bit vh[DLY];
  bit dh[DLY];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CNT_W    (CW),
    .H_ACTIVE (HA),
    .H_FRONT  (HF),
    .H_SYNC   (HS),
    .H_BACK   (HB),
    .V_ACTIVE (VA),
    .V_FRONT  (VF),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .HS_POL   (HP),
    .VS_POL   (VP),
    .SYNC_DLY (DLY)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pix_ce (pix_ce),
    .x      (x),
    .y      (y),
    .hsync  (hsync),
    .vsync  (vsync),
    .de     (de),
    .sof    (sof),
    .eol    (eol)
  );

  function automatic exp_t undel();
    exp_t e;
    e = '{x: 0, y: 0, hs: ~HP, vs: ~VP,
          de: 1'b0, sof: 1'b0, eol: 1'b0};
    if (started) begin
      e.x   = n % HT;
      e.y   = n / HT;
      e.de  = (e.x < HA) && (e.y < VA);
      e.sof = (n == 0);
      e.eol = (e.x == HA - 1) && (e.y < VA);
      e.hs  = (e.x >= HA + HF && e.x < HA + HF + HS)
            ? HP : ~HP;
      e.vs  = (e.y >= VA + VF && e.y < VA + VF + VS)
            ? VP : ~VP;
    end
    return e;
  endfunction

  task automatic clr_hist();
    for (int i = 0; i < DLY; i++) begin
      hh[i] = ~HP;
      vh[i] = ~VP;
      dh[i] = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit c);
    exp_t u;
    @(posedge clk);
    #2;
    if (rst_cur) begin
      started = 1'b0;
      clr_hist();
    end else if (ce_cur) begin
      u = undel();
      for (int i = DLY - 1; i > 0; i--) begin
        hh[i] = hh[i-1];
        vh[i] = vh[i-1];
        dh[i] = dh[i-1];
      end
      hh[0] = u.hs;
      vh[0] = u.vs;
      dh[0] = u.de;
      if (!started) begin
        started = 1'b1;
        n = 0;
      end else begin
        n = (n + 1) % FT;
      end
    end
    rst_cur = r;
    ce_cur  = c;
    reset   = r;
    pix_ce  = c;
    if (r) begin
      started = 1'b0;
      clr_hist();
      #1;
      n_chk++;
      if (x !== '0 || y !== '0 ||
          hsync !== ~HP || vsync !== ~VP ||
          de !== 1'b0 || sof !== 1'b0 ||
          eol !== 1'b0) begin
        n_fail++;
        $display({"FAIL reset t=%0t x=%0d y=%0d ",
                  "hs=%b vs=%b de=%b sof=%b eol=%b"},
                 $time, x, y, hsync, vsync, de,
                 sof, eol);
      end
    end
    u = undel();
`ifdef VGA_TIMING_SYNC_DLY_EN
    u.hs = hh[DLY-1];
    u.vs = vh[DLY-1];
    u.de = dh[DLY-1];
`endif
    q.push_back(u);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (x !== CW'(e.x) || y !== CW'(e.y) ||
          hsync !== e.hs || vsync !== e.vs ||
          de !== e.de || sof !== e.sof ||
          eol !== e.eol) begin
        n_fail++;
        $display({"FAIL outputs t=%0t ",
                  "got x=%0d y=%0d hs=%b vs=%b de=%b ",
                  "sof=%b eol=%b exp x=%0d y=%0d hs=%b ",
                  "vs=%b de=%b sof=%b eol=%b"},
                 $time, x, y, hsync, vsync, de, sof,
                 eol, e.x, e.y, e.hs, e.vs, e.de,
                 e.sof, e.eol);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout t=%0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    clr_hist();
    repeat (3) step(1'b1, 1'b0);
    repeat (2 * FT + 20) step(1'b0, 1'b1);
    repeat (FT + 5) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < 60; i++)
      step(1'b0, (i % 3) == 0);
    repeat (37) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    repeat (FT + 10) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
